// File: rtl/data_mover_cmdq_if.sv
// AXI4-Lite slave channel bundle for the DataMover command queue register file.
interface data_mover_cmdq_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/data_mover_cmdq.sv
// AXI4-Lite programmed command FIFO feeding the AXI DataMover command port, with
// status-stream decode into sticky error flags, a completion counter and an interrupt.
module data_mover_cmdq #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned ADDR_W             = 32,
    parameter int unsigned CMD_DEPTH          = 8
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    data_mover_cmdq_if.slave      s_axi,
    output logic [ADDR_W+39:0]    po_command,
    output logic                  po_valid,
    input  logic                  pi_ready,
    input  logic [7:0]            pi_sts_tdata,
    input  logic                  pi_sts_tvalid,
    output logic                  po_usr_rst,
    output logic                  po_irq
);
    localparam int unsigned CMD_W = ADDR_W + 40;
    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        RegCtrl   = 3'd0,
        RegCmd    = 3'd1,
        RegAddrLo = 3'd2,
        RegAddrHi = 3'd3,
        RegPush   = 3'd4,
        RegStatus = 3'd5,
        RegDone   = 3'd6,
        RegClr    = 3'd7
    } reg_idx_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // AXI-Lite handshake state
    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_mux;
    logic        wr_en, rd_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
    reg_idx_e    wr_idx, rd_idx;

    // Register file
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] cmd_q, addr_lo_q, strb_val;
    logic [31:0] addr_hi_rd;
    logic [ADDR_W-1:0] addr_full;
    logic        flush, push_req, clr_err, clr_ovf, hi_wr;
    logic [7:0]  last_sts_q, out_q;
    logic        err_q, ovf_q, irq_q;
    logic [31:0] done_q, done_d;
    logic        sts_ok;

    // FIFO
    logic [CMD_W-1:0] mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [LVL_W-1:0] level_q;
    logic        full, empty, push_ok, ovf_set, pop, fifo_clr;

    assign wr_addr = s_axi.awaddr;
    assign rd_addr = s_axi.araddr;
    assign wr_idx  = reg_idx_e'(wr_addr[4:2]);
    assign rd_idx  = reg_idx_e'(rd_addr[4:2]);
    // The master holds its valids through the one-cycle ready pulse.
    assign wr_en   = awready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_en   = arready_q && s_axi.arvalid;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rvalid  = rvalid_q;

    // AXI-Lite ready pulses, write response and registered read data
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= s_axi.awvalid && s_axi.wvalid && !awready_q && !bvalid_q;
            if (wr_en) bvalid_q <= 1'b1;
            else if (s_axi.bready) bvalid_q <= 1'b0;
            arready_q <= s_axi.arvalid && !arready_q && !rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Write decode into next-state strobes
    always_comb begin
        ctrl_d   = ctrl_q;
        strb_val = '0;
        flush    = 1'b0;
        push_req = 1'b0;
        clr_err  = 1'b0;
        clr_ovf  = 1'b0;
        hi_wr    = 1'b0;
        if (wr_en) begin
            case (wr_idx)
                RegCtrl: begin
                    strb_val = apply_strb({30'b0, ctrl_q}, s_axi.wdata, s_axi.wstrb);
                    ctrl_d   = strb_val[1:0];
                    flush    = strb_val[2];
                end
                RegAddrHi: hi_wr = 1'b1;
                RegPush:   push_req = s_axi.wstrb[0];
                RegClr: begin
                    clr_err = s_axi.wstrb[0] && s_axi.wdata[0];
                    clr_ovf = s_axi.wstrb[0] && s_axi.wdata[1];
                end
                default: ;
            endcase
        end
    end

    // Staging and control registers
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ctrl_q    <= '0;
            cmd_q     <= '0;
            addr_lo_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            if (wr_en && wr_idx == RegCmd) begin
                cmd_q <= apply_strb(cmd_q, s_axi.wdata, s_axi.wstrb);
            end
            if (wr_en && wr_idx == RegAddrLo) begin
                addr_lo_q <= apply_strb(addr_lo_q, s_axi.wdata, s_axi.wstrb);
            end
        end
    end

    if (ADDR_W == 64) begin : g_addr_hi
        logic [31:0] addr_hi_q;
        // Upper address half only exists for 64-bit DataMover addressing
        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) addr_hi_q <= '0;
            else if (hi_wr) addr_hi_q <= apply_strb(addr_hi_q, s_axi.wdata, s_axi.wstrb);
        end
        assign addr_full  = {addr_hi_q, addr_lo_q};
        assign addr_hi_rd = addr_hi_q;
    end else begin : g_no_addr_hi
        logic unused_hi_wr;
        assign unused_hi_wr = hi_wr;
        assign addr_full    = addr_lo_q;
        assign addr_hi_rd   = '0;
    end

    assign full     = level_q == LVL_W'(CMD_DEPTH);
    assign empty    = level_q == '0;
    // Soft reset drops pushes silently; fullness is judged before any same-cycle pop.
    assign push_ok  = push_req && !ctrl_q[0] && !full;
    assign ovf_set  = push_req && !ctrl_q[0] && full;
    assign pop      = !empty && pi_ready;
    // Using ctrl_d lets the queue empty on the very edge that sets soft reset.
    assign fifo_clr = flush || ctrl_d[0];

    assign po_valid   = !empty;
    assign po_command = empty ? '0 : mem_q[rptr_q];
    assign po_usr_rst = ctrl_q[0];
    assign po_irq     = irq_q;

    // Command storage; contents are masked by po_valid so no reset needed
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) mem_q[wptr_q] <= {4'b0, s_axi.wdata[3:0], addr_full, cmd_q};
    end

    // FIFO pointers, level and outstanding-command count
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            out_q   <= '0;
        end else if (fifo_clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            out_q   <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: ;
            endcase
            case ({pop, pi_sts_tvalid})
                2'b10:   if (out_q != 8'hFF) out_q <= out_q + 8'd1;
                2'b01:   if (out_q != 8'h00) out_q <= out_q - 8'd1;
                default: ;
            endcase
        end
    end

    assign sts_ok = pi_sts_tdata[7] && (pi_sts_tdata[6:4] == 3'b000);

    // Read-clear of DONE_CNT takes priority, then a same-cycle completion counts
    always_comb begin
        done_d = (rd_en && rd_idx == RegDone) ? '0 : done_q;
        if (pi_sts_tvalid && sts_ok && done_d != '1) done_d = done_d + 32'd1;
    end

    // Status capture, sticky flags, completion counter and interrupt
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            last_sts_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (pi_sts_tvalid) last_sts_q <= pi_sts_tdata;
            if (pi_sts_tvalid && !sts_ok) err_q <= 1'b1;
            else if (clr_err) err_q <= 1'b0;
            if (ovf_set) ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
            done_q <= done_d;
            irq_q  <= ctrl_q[1] && (done_q != '0 || err_q || ovf_q);
        end
    end

    // Read data mux
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            RegCtrl:   rd_mux = {30'b0, ctrl_q};
            RegCmd:    rd_mux = cmd_q;
            RegAddrLo: rd_mux = addr_lo_q;
            RegAddrHi: rd_mux = addr_hi_rd;
            RegStatus: rd_mux = {out_q, 4'b0, err_q, ovf_q, empty, full, 8'(level_q), last_sts_q};
            RegDone:   rd_mux = done_q;
            default:   rd_mux = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], s_axi.awprot, s_axi.arprot};
endmodule

// File: tb/tb_data_mover_cmdq.sv
// Scoreboard bench: a 32-bit and a 64-bit address instance share one AXI-Lite stimulus stream.
module tb_data_mover_cmdq;
    logic S_AXI_ACLK = 1'b0;
    logic S_AXI_ARESET;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    data_mover_cmdq_if bus ();
    data_mover_cmdq_if bus64 ();

    assign bus64.awaddr  = bus.awaddr;
    assign bus64.awprot  = bus.awprot;
    assign bus64.awvalid = bus.awvalid;
    assign bus64.wdata   = bus.wdata;
    assign bus64.wstrb   = bus.wstrb;
    assign bus64.wvalid  = bus.wvalid;
    assign bus64.bready  = bus.bready;
    assign bus64.araddr  = bus.araddr;
    assign bus64.arprot  = bus.arprot;
    assign bus64.arvalid = bus.arvalid;
    assign bus64.rready  = bus.rready;

    logic [71:0]  cmd32;
    logic [103:0] cmd64;
    logic valid32, valid64, usr_rst32, usr_rst64, irq32, irq64;
    logic pi_ready, sts_tvalid;
    logic [7:0] sts_tdata;

    data_mover_cmdq #(.ADDR_W(32), .CMD_DEPTH(8)) dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET), .s_axi(bus),
        .po_command(cmd32), .po_valid(valid32), .pi_ready(pi_ready),
        .pi_sts_tdata(sts_tdata), .pi_sts_tvalid(sts_tvalid),
        .po_usr_rst(usr_rst32), .po_irq(irq32)
    );

    data_mover_cmdq #(.ADDR_W(64), .CMD_DEPTH(8)) dut64 (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET), .s_axi(bus64),
        .po_command(cmd64), .po_valid(valid64), .pi_ready(pi_ready),
        .pi_sts_tdata(sts_tdata), .pi_sts_tvalid(sts_tvalid),
        .po_usr_rst(usr_rst64), .po_irq(irq64)
    );

    int checks = 0;
    int failures = 0;
    logic [71:0]  exp32_q[$];
    logic [103:0] exp64_q[$];
    logic [31:0]  rd_exp_q[$];
    string        rd_name_q[$];
    logic [31:0]  m_cmd = '0, m_lo = '0, m_hi = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted command and every read beat against the scoreboard
    always @(negedge S_AXI_ACLK) begin
        if (!S_AXI_ARESET) begin
            if (valid32 && pi_ready) begin
                if (exp32_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd32_unexpected actual=%0h required=none", cmd32);
                end else check("cmd32", cmd32, exp32_q.pop_front());
            end
            if (valid64 && pi_ready) begin
                if (exp64_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd64_unexpected actual=%0h required=none", cmd64);
                end else check("cmd64", cmd64, exp64_q.pop_front());
            end
            if (bus.rvalid && bus.rready) begin
                if (rd_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rdata_unexpected actual=%0h required=none", bus.rdata);
                end else check(rd_name_q.pop_front(), bus.rdata, rd_exp_q.pop_front());
            end
        end
    end

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb = 4'hF, input bit pop_at_edge = 1'b0);
        bit found = 1'b0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge S_AXI_ACLK); #1;
            found = bus.awready && bus.wready;
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL write_timeout actual=no_awready required=awready");
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            return;
        end
        if (pop_at_edge) pi_ready = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (pop_at_edge) pi_ready = 1'b0;
        check("bvalid", {bus.bvalid, bus.bresp}, {1'b1, 2'b00});
        @(posedge S_AXI_ACLK); #1;
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data);
        if (addr == 5'h04) m_cmd = data;
        if (addr == 5'h08) m_lo = data;
        if (addr == 5'h0C) m_hi = data;
        axi_write(addr, data);
    endtask

    task automatic do_push(input logic [3:0] tag, input bit accept, input bit pop_at_edge = 1'b0);
        if (accept) begin
            exp32_q.push_back({4'b0, tag, m_lo, m_cmd});
            exp64_q.push_back({4'b0, tag, m_hi, m_lo, m_cmd});
        end
        axi_write(5'h10, {28'b0, tag}, 4'hF, pop_at_edge);
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        bit found = 1'b0;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        bus.araddr = addr; bus.arvalid = 1'b1;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge S_AXI_ACLK); #1;
            found = bus.arready;
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL read_timeout %s actual=no_arready required=arready", name);
            bus.arvalid = 1'b0;
            return;
        end
        @(posedge S_AXI_ACLK); #1;
        bus.arvalid = 1'b0;
        @(posedge S_AXI_ACLK); #1;
    endtask

    task automatic send_sts(input logic [7:0] s);
        sts_tdata = s; sts_tvalid = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        sts_tvalid = 1'b0;
    endtask

    task automatic flush_model();
        exp32_q.delete();
        exp64_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        S_AXI_ARESET = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        pi_ready = 1'b0; sts_tvalid = 1'b0; sts_tdata = '0;
        repeat (3) @(posedge S_AXI_ACLK);
        #1;
        check("reset_outputs", {valid32, irq32, usr_rst32, cmd32}, '0);
        check("reset_axi", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata}, '0);
        S_AXI_ARESET = 1'b0;
        @(posedge S_AXI_ACLK); #1;

        // Single command passes straight through
        pi_ready = 1'b1;
        wr_reg(5'h04, 32'h4080_0100);
        wr_reg(5'h08, 32'h1000_0000);
        do_push(4'h5, 1'b1);
        check("valid_one_cycle", valid32, 1'b0);
        axi_write(5'h10, 32'h5, 4'hE);   // no byte-0 strobe: not a push
        axi_read(5'h14, 32'h0102_0000, "status_after_single");
        axi_write(5'h04, 32'h1234_AA78, 4'b0010);
        axi_read(5'h04, 32'h4080_AA00, "cmd_wstrb");
        wr_reg(5'h04, 32'h4080_0100);

        // Fill past full with irq enabled
        pi_ready = 1'b0;
        wr_reg(5'h00, 32'h2);
        for (int t = 0; t < 8; t++) do_push(4'(t), 1'b1);
        do_push(4'h8, 1'b0);
        axi_read(5'h14, 32'h0105_0800, "status_full_ovf");
        check("irq_ovf", irq32, 1'b1);
        wr_reg(5'h1C, 32'h2);
        axi_read(5'h14, 32'h0101_0800, "status_ovf_cleared");
        check("irq_cleared", irq32, 1'b0);
        pi_ready = 1'b1;
        repeat (12) @(posedge S_AXI_ACLK);
        #1;
        check("drain32_all", exp32_q.size(), 0);
        pi_ready = 1'b0;

        // Status decode
        send_sts(8'h85);
        send_sts(8'hC6);
        axi_read(5'h18, 32'd1, "done_first");
        axi_read(5'h18, 32'd0, "done_cleared");
        axi_read(5'h14, 32'h070A_00C6, "status_after_sts");
        check("irq_err", irq32, 1'b1);
        fork
            axi_read(5'h18, 32'd0, "done_race_read");
            begin
                @(posedge S_AXI_ACLK); #1;
                sts_tdata = 8'h87; sts_tvalid = 1'b1;
                @(posedge S_AXI_ACLK); #1;
                sts_tvalid = 1'b0;
            end
        join
        axi_read(5'h18, 32'd1, "done_after_race");
        wr_reg(5'h1C, 32'h1);
        check("irq_err_cleared", irq32, 1'b0);

        // Simultaneous push and pop
        do_push(4'h1, 1'b1);
        do_push(4'h2, 1'b1);
        do_push(4'h3, 1'b1);
        do_push(4'h4, 1'b1, 1'b1);
        axi_read(5'h14, 32'h0700_0387, "status_push_pop_l3");
        for (int t = 5; t < 10; t++) do_push(4'(t), 1'b1);
        do_push(4'hA, 1'b0, 1'b1);
        axi_read(5'h14, 32'h0804_0787, "status_push_pop_full");

        // Flush
        wr_reg(5'h00, 32'h6);
        flush_model();
        check("flush_valid", {valid32, valid64}, 2'b00);
        axi_read(5'h00, 32'h2, "ctrl_flush_selfclr");
        axi_read(5'h14, 32'h0006_0087, "status_after_flush");
        wr_reg(5'h1C, 32'h2);

        // 64-bit addressing and soft reset
        wr_reg(5'h0C, 32'h0000_000A);
        wr_reg(5'h08, 32'h0000_000B);
        axi_read(5'h0C, 32'h0, "addr_hi_32_reads0");
        do_push(4'hF, 1'b1);
        check("cmd64_hi", cmd64[103:32], 72'h0F_0000_000A_0000_000B);
        check("cmd32_tag_f", cmd32, 72'h0F_0000_000B_4080_0100);
        do_push(4'h1, 1'b1);
        do_push(4'h2, 1'b1);
        do_push(4'h3, 1'b1);
        wr_reg(5'h00, 32'h3);
        flush_model();
        check("softrst_outputs", {valid32, valid64, usr_rst32, usr_rst64}, 4'b0011);
        do_push(4'h4, 1'b0);
        axi_read(5'h14, 32'h0002_0087, "status_softrst_no_ovf");
        axi_read(5'h00, 32'h3, "ctrl_softrst");
        wr_reg(5'h00, 32'h2);
        check("softrst_released", usr_rst32, 1'b0);

        // Asynchronous reset in the middle of a burst
        do_push(4'h5, 1'b1);
        do_push(4'h6, 1'b1);
        #3;
        S_AXI_ARESET = 1'b1;
        #1;
        flush_model();
        check("async_rst_outputs", {valid32, valid64, irq32, usr_rst32, cmd32, cmd64}, '0);
        check("async_rst_axi", {bus.awready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata}, '0);
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESET = 1'b0;
        pi_ready = 1'b1;
        repeat (4) @(posedge S_AXI_ACLK);
        #1;
        check("post_reset_idle", valid32, 1'b0);
        axi_read(5'h14, 32'h0002_0000, "status_post_reset");
        axi_read(5'h00, 32'h0, "ctrl_post_reset");

        check("exp32_drained", exp32_q.size(), 0);
        check("exp64_drained", exp64_q.size(), 0);
        check("reads_drained", rd_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
